// File: rtl/xalu_muldiv_if.sv
// EX-stage handshake between the decoder/hazard logic and the xalu_muldiv unit.
// master = pipeline side, slave = multiply/divide unit.
interface xalu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo, rd_data
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo, rd_data
   );
endinterface

// File: rtl/xalu_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define XALU_MADD_EN to add madd/maddu/msub/msubu accumulate ops (codes 9-12).
module xalu_muldiv #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic         clk,
   input logic         rst_n,
   xalu_muldiv_if.slave bus
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic {IDLE, RUN} state_t;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_MTHI  = 4'd3,
      OP_MTLO  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_DIV   = 4'd7,
      OP_DIVU  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } op_t;

   typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [2*WIDTH-1:0] res_q;
   acc_t               acc_q;

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic               div_signed;
   logic               dvd_neg;
   logic               dvs_neg;
   logic [WIDTH-1:0]   dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   logic               launch_long;
   logic [CW-1:0]      launch_cnt;
   logic [2*WIDTH-1:0] launch_res;
   acc_t               launch_acc;

   // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed product.
   assign prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
   assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

   // Signed divide runs on magnitudes; most-negative / -1 falls out naturally after re-signing.
   always_comb begin
      div_signed = (bus.op == OP_DIV);
      dvd_neg    = div_signed & bus.a[WIDTH-1];
      dvs_neg    = div_signed & bus.b[WIDTH-1];
      dvd_mag    = dvd_neg ? -bus.a : bus.a;
      dvs_mag    = dvs_neg ? -bus.b : bus.b;
      q_mag      = '0;
      r_mag      = '0;
      quot       = '1;
      rem        = bus.a;
      if (dvs_mag != '0) begin
         q_mag = dvd_mag / dvs_mag;
         r_mag = dvd_mag % dvs_mag;
         quot  = (dvd_neg ^ dvs_neg) ? -q_mag : q_mag;
         rem   = dvd_neg ? -r_mag : r_mag;
      end
   end

   always_comb begin
      launch_long = 1'b0;
      launch_cnt  = '0;
      launch_res  = '0;
      launch_acc  = ACC_SET;
      case (bus.op)
         OP_MULT: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(MULT_CYCLES);
            launch_res  = prod_s;
         end
         OP_MULTU: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(MULT_CYCLES);
            launch_res  = prod_u;
         end
         OP_DIV, OP_DIVU: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(DIV_CYCLES);
            launch_res  = {rem, quot};
         end
`ifdef XALU_MADD_EN
         OP_MADD: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(MULT_CYCLES);
            launch_res  = prod_s;
            launch_acc  = ACC_ADD;
         end
         OP_MADDU: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(MULT_CYCLES);
            launch_res  = prod_u;
            launch_acc  = ACC_ADD;
         end
         OP_MSUB: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(MULT_CYCLES);
            launch_res  = prod_s;
            launch_acc  = ACC_SUB;
         end
         OP_MSUBU: begin
            launch_long = 1'b1;
            launch_cnt  = CW'(MULT_CYCLES);
            launch_res  = prod_u;
            launch_acc  = ACC_SUB;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         res_q  <= '0;
         acc_q  <= ACC_SET;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  if (launch_long) begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                     cnt    <= launch_cnt;
                     res_q  <= launch_res;
                     acc_q  <= launch_acc;
                  end else if (bus.op == OP_MTHI) begin
                     hi_q <= bus.a;
                  end else if (bus.op == OP_MTLO) begin
                     lo_q <= bus.a;
                  end
               end
            end
            RUN: begin
               // Flush wins over a commit landing on the same edge.
               if (bus.flush) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  cnt    <= '0;
               end else if (cnt == CW'(1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cnt    <= '0;
                  case (acc_q)
                     ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + res_q;
                     ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - res_q;
                     default: {hi_q, lo_q} <= res_q;
                  endcase
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.rd_data = '0;
      if (bus.op == OP_MFHI)
         bus.rd_data = hi_q;
      else if (bus.op == OP_MFLO)
         bus.rd_data = lo_q;
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv: transaction-level HI/LO model with commit timestamps,
// directed literal cases, then randomized traffic with flushes and resets.
module tb_xalu_muldiv;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xalu_muldiv_if #(.WIDTH(W)) bus ();

   xalu_muldiv #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_long(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd7, 4'd8: return 1'b1;
`ifdef XALU_MADD_EN
         4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic int model_kind(input logic [3:0] op);
      if (op == 4'd9 || op == 4'd10) return 1;
      if (op == 4'd11 || op == 4'd12) return 2;
      return 0;
   endfunction

   function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      int          sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = int'(a);
      sb = int'(b);
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         4'd1, 4'd9, 4'd11: return 64'(longint'(sa) * longint'(sb));
         4'd2, 4'd10, 4'd12: return ua * ub;
         4'd7: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         4'd8: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   bit          m_pend = 1'b0;
   bit          m_done = 1'b0;
   longint      cyc = 0;
   longint      m_commit = 0;
   logic [63:0] m_res = '0;
   int          m_kind = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (!rst_n) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_pend <= 1'b0;
      end else if (m_pend) begin
         if (bus.flush) begin
            m_pend <= 1'b0;
         end else if (cyc == m_commit) begin
            m_pend <= 1'b0;
            m_done <= 1'b1;
            case (m_kind)
               1:       {m_hi, m_lo} <= {m_hi, m_lo} + m_res;
               2:       {m_hi, m_lo} <= {m_hi, m_lo} - m_res;
               default: {m_hi, m_lo} <= m_res;
            endcase
         end
      end else if (bus.start && !bus.flush) begin
         if (is_long(bus.op)) begin
            m_pend   <= 1'b1;
            m_commit <= cyc + ((bus.op == 4'd7 || bus.op == 4'd8) ? DC : MC);
            m_res    <= model_result(bus.op, bus.a, bus.b);
            m_kind   <= model_kind(bus.op);
         end else if (bus.op == 4'd3) begin
            m_hi <= bus.a;
         end else if (bus.op == 4'd4) begin
            m_lo <= bus.a;
         end
      end
   end

   // Every cycle: DUT outputs against the model.
   always @(posedge clk) begin
      #1;
      chk("busy", bus.busy, m_pend);
      chk("done", bus.done, m_done);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("rd_data", bus.rd_data,
          (bus.op == 4'd5) ? m_hi : ((bus.op == 4'd6) ? m_lo : 32'h0));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit st, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl);
      @(negedge clk);
      bus.start = st;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.flush = fl;
   endtask

   // Launch one op and watch a bounded window; first_done is the idle-cycle index of done.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int first_done, output int ndone);
      drive(1'b1, op, a, b, 1'b0);
      first_done = -1;
      ndone      = 0;
      for (int i = 0; i < DC + 3; i++) begin
         drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
         #1;
         if (bus.done) begin
            ndone++;
            if (first_done < 0) first_done = i;
         end
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         5:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int fd, nd;
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_hi", bus.hi, 32'h0);
      chk("reset_lo", bus.lo, 32'h0);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_done", bus.done, 1'b0);

      run_op(4'd1, 32'hFFFF_FFFE, 32'h3, fd, nd);
      chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
      chk("mult_latency", fd, MC);
      chk("mult_done_count", nd, 1);

      run_op(4'd2, 32'hFFFF_FFFE, 32'h3, fd, nd);
      chk("multu_hi", bus.hi, 32'h0000_0002);
      chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

      run_op(4'd7, 32'hFFFF_FFF9, 32'h2, fd, nd);
      chk("div_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi, 32'hFFFF_FFFF);
      chk("div_latency", fd, DC);

      run_op(4'd8, 32'h7, 32'h0, fd, nd);
      chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
      chk("divu0_hi", bus.hi, 32'h7);
      chk("divu0_latency", fd, DC);

      run_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, fd, nd);
      chk("divovf_lo", bus.lo, 32'h8000_0000);
      chk("divovf_hi", bus.hi, 32'h0);

      // mthi issued while a mult is in flight must be dropped
      drive(1'b1, 4'd1, 32'h3, 32'h4, 1'b0);
      drive(1'b1, 4'd3, 32'h1234, 32'h0, 1'b0);
      #1;
      chk("busy_in_run", bus.busy, 1'b1);
      repeat (MC + 2) drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      chk("mthi_busy_hi", bus.hi, 32'h0);
      chk("mthi_busy_lo", bus.lo, 32'd12);

      drive(1'b1, 4'd3, 32'h1234, 32'h0, 1'b0);
      drive(1'b0, 4'd5, 32'h0, 32'h0, 1'b0);
      #1;
      chk("mthi_idle_hi", bus.hi, 32'h1234);
      chk("mfhi_rd_data", bus.rd_data, 32'h1234);

      // flush on the third cycle of a div
      drive(1'b1, 4'd3, 32'h5, 32'h0, 1'b0);
      drive(1'b1, 4'd4, 32'h6, 32'h0, 1'b0);
      drive(1'b1, 4'd7, 32'd100, 32'd10, 1'b0);
      drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
      drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("flush_busy", bus.busy, 1'b0);
      nd = 0;
      for (int i = 0; i < DC + 2; i++) begin
         drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
         #1;
         if (bus.done) nd++;
      end
      chk("flush_no_done", nd, 0);
      chk("flush_hi", bus.hi, 32'h5);
      chk("flush_lo", bus.lo, 32'h6);

      drive(1'b1, 4'd1, 32'h2, 32'h3, 1'b1);
      drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("start_flush_busy", bus.busy, 1'b0);

`ifdef XALU_MADD_EN
      drive(1'b1, 4'd3, 32'h0, 32'h0, 1'b0);
      drive(1'b1, 4'd4, 32'hFFFF_FFFF, 32'h0, 1'b0);
      run_op(4'd9, 32'h1, 32'h1, fd, nd);
      chk("madd_hi", bus.hi, 32'h1);
      chk("madd_lo", bus.lo, 32'h0);
      chk("madd_latency", fd, MC);
      run_op(4'd11, 32'h1, 32'h1, fd, nd);
      chk("msub_hi", bus.hi, 32'h0);
      chk("msub_lo", bus.lo, 32'hFFFF_FFFF);
`endif

      for (int n = 0; n < 3000; n++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pick(), pick(),
               ($urandom_range(0, 15) == 0));
         rst_n = ($urandom_range(0, 299) != 0);
      end
      drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
      repeat (DC + 2) drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
      #2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Driven by the decoder's 4-bit XALUOp encoding.
- Sits in the EX stage beside the main ALU.
- Exposes `busy` so the hazard unit stalls any HI/LO-touching instruction while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width (≥8).
- MULT_CYCLES, 5, cycles from accepted mult/multu start to result commit (≥1).
- DIV_CYCLES, 10, cycles from accepted div/divu start to result commit (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  op valid this cycle.
- op  in  4  XALUOp: 0 nop, 1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu; others nop.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- flush  in  1  abort in-flight op (exception/branch squash).
- busy  out  1  registered; high while a mult/div is in flight.
- done  out  1  registered; one-cycle pulse on the cycle HI/LO take a mult/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  combinational: hi when op=5, lo when op=6, else 0.

Behaviour:
- Reset (rst_n low at posedge): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Reset mid-operation discards the operation.
- States: IDLE, RUN.
- IDLE, start with op 1/2/7/8:
  - latch a, b and op.
  - load counter with MULT_CYCLES or DIV_CYCLES.
  - go to RUN; busy=1 from the next cycle.
- IDLE, start with op 3: hi<=a next edge, no busy.
- IDLE, start with op 4: lo<=a next edge, no busy.
- op 5/6: no state change; rd_data is valid in the same cycle.
- RUN: counter decrements each cycle.
  - The edge where counter reaches 1 writes {hi,lo}, clears busy, pulses done, returns to IDLE.
  - Latency for a multiply: start at edge 0, result visible after edge MULT_CYCLES.
- Any start while busy=1 is ignored, including mthi/mtlo/mfhi/mflo. The hazard unit must stall; rd_data still reflects current hi/lo.
- Multiply results:
  - mult: signed WIDTH×WIDTH → 2·WIDTH product; hi=upper half, lo=lower half.
  - multu: same, unsigned.
- Divide results:
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned.
- Divide by zero: lo=all ones, hi=a; runs full DIV_CYCLES.
- Signed div with a=most-negative and b=−1: lo=most-negative, hi=0.
- flush:
  - In RUN: return to IDLE next edge, busy=0, no done, hi/lo unchanged.
  - In the same cycle as start: the start is dropped.
  - flush has priority over commit on the final cycle.
- The result can be computed combinationally at launch and held until commit; only the timing is architecturally visible.

Optional Feature:
- Macro XALU_MADD_EN.
- Defined: adds op codes accepted with MULT_CYCLES latency, each updating {hi,lo} as 2·WIDTH modular arithmetic:
  - 9 madd: {hi,lo} += signed a×b.
  - 10 maddu: {hi,lo} += unsigned a×b.
  - 11 msub: {hi,lo} −= signed a×b.
  - 12 msubu: {hi,lo} −= unsigned a×b.
- The accumulate uses the {hi,lo} value at commit time.
- Undefined: codes 9–12 are treated as nop.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 → hi=0, lo=0, busy=0, done=0.
- mult a=0xFFFFFFFE (−2), b=3, then multu with the same operands:
  - mult → after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses exactly once.
  - multu → hi=0x00000002, lo=0xFFFFFFFA.
- div a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi a=0x1234 while busy → ignored, hi unchanged.
  - mthi a=0x1234 in IDLE → hi=0x1234 next cycle.
  - mfhi → rd_data=0x1234 same cycle.
- flush on cycle 3 of a div with a=100, b=10 (hi=5, lo=6 beforehand) → busy falls next edge, no done, hi=5, lo=6 retained.
- With XALU_MADD_EN and hi=0, lo=0xFFFFFFFF: madd a=1, b=1 → hi=1, lo=0; msub a=1, b=1 → hi=0, lo=0xFFFFFFFF.
